alu_seq_core: RTL and testbench

//  Parametrised sequential ALU core with operand collection, a timeout on a missing operand, and registered results.

---
 rtl/alu_seq_core_if.sv | 33 +++
 rtl/alu_seq_core.sv | 277 +++++++++++++++++++++++++++
 tb/tb_alu_seq_core.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_core_if.sv
// Operand/command bus and result bus between the operand source, the ALU core
// and the result checker.
interface alu_seq_core_if #(
    parameter int DW = 8,
    parameter int CW = 4
);
    logic [1:0]      INP_VALID;
    logic            MODE;
    logic [CW-1:0]   CMD;
    logic            CIN;
    logic [DW-1:0]   OPA;
    logic [DW-1:0]   OPB;

    logic            BUSY;
    logic [2*DW-1:0] RES;
    logic            COUT;
    logic            OFLOW;
    logic            G;
    logic            E;
    logic            L;
    logic            ERR;
    logic            RES_VALID;

    modport master (
        output INP_VALID, MODE, CMD, CIN, OPA, OPB,
        input  BUSY, RES, COUT, OFLOW, G, E, L, ERR, RES_VALID
    );

    modport slave (
        input  INP_VALID, MODE, CMD, CIN, OPA, OPB,
        output BUSY, RES, COUT, OFLOW, G, E, L, ERR, RES_VALID
    );
endinterface

// File: rtl/alu_seq_core.sv
// Sequential ALU core: collects operands in one or two beats (with a timeout on a
// missing partner), executes, and registers results with a one-cycle strobe.
module alu_seq_core #(
    parameter int DW      = 8,
    parameter int CW      = 4,
    parameter int TIMEOUT = 16
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         CE,
    alu_seq_core_if.slave bus
);
    localparam int LW    = $clog2(DW);
    localparam int H     = DW / 2;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int PLW   = DW + 1 + H;
    localparam int PHW   = 2 * DW + 2 - H;

    typedef enum logic [2:0] {IDLE, WAIT_B, WAIT_A, EXEC, MUL} state_t;

    state_t          state;
    logic [CNT_W-1:0] cnt;

    logic [DW-1:0]   opa_p0;
    logic [DW-1:0]   opb_p0;
    logic [CW-1:0]   cmd_p0;
    logic            mode_p0;
    logic            cin_p0;

    logic [PLW-1:0]  pp_lo_p1;
    logic [PHW-1:0]  pp_hi_p1;

    logic [2*DW-1:0] res_p2;
    logic            cout_p2;
    logic            oflow_p2;
    logic            g_p2;
    logic            e_p2;
    logic            l_p2;
    logic            err_p2;
    logic            vld_p2;

    function automatic logic [2*DW-1:0] zx(input logic [DW-1:0] v);
        return {{DW{1'b0}}, v};
    endfunction

    function automatic logic [DW-1:0] rotl(input logic [DW-1:0] v, input logic [LW-1:0] n);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < DW; i++)
            r[(i + int'(n)) % DW] = v[i];
        return r;
    endfunction

    function automatic logic [DW-1:0] rotr(input logic [DW-1:0] v, input logic [LW-1:0] n);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < DW; i++)
            r[i] = v[(i + int'(n)) % DW];
        return r;
    endfunction

    logic [31:0]     op;
    logic            is_mul;
    logic            cin_add;
    logic            cin_sub;
    logic [DW:0]     sum_n;
    logic [2*DW-1:0] diff_n;
    logic            borrow_n;
    logic [DW-1:0]   inc_a;
    logic [DW-1:0]   dec_a;
    logic [DW-1:0]   inc_b;
    logic [DW-1:0]   dec_b;
    logic [DW:0]     fa_n;
    logic [DW:0]     fb_n;
    logic [PLW-1:0]  pp_lo_n;
    logic [PHW-1:0]  pp_hi_n;
    logic [2*DW-1:0] prod_n;

    assign op       = 32'(cmd_p0);
    assign is_mul   = mode_p0 && (op == 32'd9 || op == 32'd10);
    assign cin_add  = (op == 32'd2) & cin_p0;
    assign cin_sub  = (op == 32'd3) & cin_p0;
    assign sum_n    = {1'b0, opa_p0} + {1'b0, opb_p0} + (DW+1)'(cin_add);
    assign diff_n   = (2*DW)'(opa_p0) - (2*DW)'(opb_p0) - (2*DW)'(cin_sub);
    assign borrow_n = {1'b0, opa_p0} < ({1'b0, opb_p0} + (DW+1)'(cin_sub));
    assign inc_a    = opa_p0 + DW'(1);
    assign dec_a    = opa_p0 - DW'(1);
    assign inc_b    = opb_p0 + DW'(1);
    assign dec_b    = opb_p0 - DW'(1);

    // Multiply stage 1: DW+1-bit factors, B split into two halves.
    assign fa_n    = (op == 32'd9) ? ({1'b0, opa_p0} + (DW+1)'(1)) : {1'b0, opa_p0[DW-2:0], 1'b0};
    assign fb_n    = (op == 32'd9) ? ({1'b0, opb_p0} + (DW+1)'(1)) : {1'b0, opb_p0};
    assign pp_lo_n = PLW'(fa_n) * PLW'(fb_n[H-1:0]);
    assign pp_hi_n = PHW'(fa_n) * PHW'(fb_n[DW:H]);
    // Multiply stage 2: recombine partial products, keep the low 2*DW bits.
    assign prod_n  = (2*DW)'(pp_lo_p1) + ((2*DW)'(pp_hi_p1) << H);

    logic [2*DW-1:0] res_n;
    logic            cout_n;
    logic            oflow_n;
    logic            g_n;
    logic            e_n;
    logic            l_n;
    logic            err_n;

    always_comb begin
        res_n   = '0;
        cout_n  = 1'b0;
        oflow_n = 1'b0;
        g_n     = 1'b0;
        e_n     = 1'b0;
        l_n     = 1'b0;
        err_n   = 1'b0;
        if (mode_p0) begin
            case (op)
                32'd0, 32'd2: begin res_n = (2*DW)'(sum_n); cout_n = sum_n[DW]; end
                32'd1, 32'd3: begin res_n = diff_n; oflow_n = borrow_n; end
                32'd4: begin res_n = zx(inc_a); oflow_n = (opa_p0 == '1); end
                32'd5: begin res_n = zx(dec_a); oflow_n = (opa_p0 == '0); end
                32'd6: begin res_n = zx(inc_b); oflow_n = (opb_p0 == '1); end
                32'd7: begin res_n = zx(dec_b); oflow_n = (opb_p0 == '0); end
                32'd8: begin
                    g_n = opa_p0 > opb_p0;
                    e_n = opa_p0 == opb_p0;
                    l_n = opa_p0 < opb_p0;
                end
                default: err_n = 1'b1;
            endcase
        end else begin
            case (op)
                32'd0:  res_n = zx(opa_p0 & opb_p0);
                32'd1:  res_n = zx(~(opa_p0 & opb_p0));
                32'd2:  res_n = zx(opa_p0 | opb_p0);
                32'd3:  res_n = zx(~(opa_p0 | opb_p0));
                32'd4:  res_n = zx(opa_p0 ^ opb_p0);
                32'd5:  res_n = zx(~(opa_p0 ^ opb_p0));
                32'd6:  res_n = zx(~opa_p0);
                32'd7:  res_n = zx(~opb_p0);
                32'd8:  res_n = zx(opa_p0 >> 1);
                32'd9:  res_n = zx(opa_p0 << 1);
                32'd10: res_n = zx(opb_p0 >> 1);
                32'd11: res_n = zx(opb_p0 << 1);
                32'd12: begin
                    res_n = zx(rotl(opa_p0, opb_p0[LW-1:0]));
                    err_n = |opb_p0[DW-1:LW];
                end
                32'd13: begin
                    res_n = zx(rotr(opa_p0, opb_p0[LW-1:0]));
                    err_n = |opb_p0[DW-1:LW];
                end
                default: err_n = 1'b1;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            cnt      <= '0;
            opa_p0   <= '0;
            opb_p0   <= '0;
            cmd_p0   <= '0;
            mode_p0  <= 1'b0;
            cin_p0   <= 1'b0;
            pp_lo_p1 <= '0;
            pp_hi_p1 <= '0;
            res_p2   <= '0;
            cout_p2  <= 1'b0;
            oflow_p2 <= 1'b0;
            g_p2     <= 1'b0;
            e_p2     <= 1'b0;
            l_p2     <= 1'b0;
            err_p2   <= 1'b0;
            vld_p2   <= 1'b0;
        end else if (!CE) begin
            vld_p2 <= 1'b0;
        end else begin
            vld_p2 <= 1'b0;
            case (state)
                // Operand collection: command fields are taken from the first beat only.
                IDLE: begin
                    if (bus.INP_VALID != 2'b00) begin
                        cmd_p0  <= bus.CMD;
                        mode_p0 <= bus.MODE;
                        cin_p0  <= bus.CIN;
                        cnt     <= '0;
                    end
                    if (bus.INP_VALID[0]) opa_p0 <= bus.OPA;
                    if (bus.INP_VALID[1]) opb_p0 <= bus.OPB;
                    case (bus.INP_VALID)
                        2'b11:   state <= EXEC;
                        2'b01:   state <= WAIT_B;
                        2'b10:   state <= WAIT_A;
                        default: state <= IDLE;
                    endcase
                end
                WAIT_B: begin
                    if (bus.INP_VALID[1]) begin
                        opb_p0 <= bus.OPB;
                        state  <= EXEC;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        res_p2   <= '0;
                        cout_p2  <= 1'b0;
                        oflow_p2 <= 1'b0;
                        g_p2     <= 1'b0;
                        e_p2     <= 1'b0;
                        l_p2     <= 1'b0;
                        err_p2   <= 1'b1;
                        vld_p2   <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_A: begin
                    if (bus.INP_VALID[0]) begin
                        opa_p0 <= bus.OPA;
                        state  <= EXEC;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        res_p2   <= '0;
                        cout_p2  <= 1'b0;
                        oflow_p2 <= 1'b0;
                        g_p2     <= 1'b0;
                        e_p2     <= 1'b0;
                        l_p2     <= 1'b0;
                        err_p2   <= 1'b1;
                        vld_p2   <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                // Execute: multiplies detour through the partial-product register.
                EXEC: begin
                    if (is_mul) begin
                        pp_lo_p1 <= pp_lo_n;
                        pp_hi_p1 <= pp_hi_n;
                        state    <= MUL;
                    end else begin
                        res_p2   <= res_n;
                        cout_p2  <= cout_n;
                        oflow_p2 <= oflow_n;
                        g_p2     <= g_n;
                        e_p2     <= e_n;
                        l_p2     <= l_n;
                        err_p2   <= err_n;
                        vld_p2   <= 1'b1;
                        state    <= IDLE;
                    end
                end
                MUL: begin
                    res_p2   <= prod_n;
                    cout_p2  <= 1'b0;
                    oflow_p2 <= 1'b0;
                    g_p2     <= 1'b0;
                    e_p2     <= 1'b0;
                    l_p2     <= 1'b0;
                    err_p2   <= 1'b0;
                    vld_p2   <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.BUSY      = (state != IDLE);
    assign bus.RES       = res_p2;
    assign bus.COUT      = cout_p2;
    assign bus.OFLOW     = oflow_p2;
    assign bus.G         = g_p2;
    assign bus.E         = e_p2;
    assign bus.L         = l_p2;
    assign bus.ERR       = err_p2;
    assign bus.RES_VALID = vld_p2;
endmodule

// File: tb/tb_alu_seq_core.sv
// Bench for alu_seq_core: directed scenarios plus randomized operations checked
// against an arithmetic reference model.
module tb_alu_seq_core;
    localparam int DW = 8;
    localparam int CW = 4;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ce = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq_core_if #(.DW(DW), .CW(CW)) bus ();

    alu_seq_core #(.DW(DW), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
        .CLK(clk),
        .RST_N(rst_n),
        .CE(ce),
        .bus(bus.slave)
    );

    // Expected {RES, COUT, OFLOW, G, E, L, ERR} from the operation definitions.
    function automatic logic [21:0] model(input logic m, input logic [3:0] c, input logic ci,
                                          input logic [7:0] a8, input logic [7:0] b8);
        int a, b, n, r, cin;
        logic co, ov, g, e, l, er;
        a = a8; b = b8; cin = ci; n = b % 8; r = 0;
        co = 0; ov = 0; g = 0; e = 0; l = 0; er = 0;
        if (m) begin
            case (c)
                0:  begin r = a + b; co = (r > 255); end
                1:  begin r = a - b; ov = (a < b); end
                2:  begin r = a + b + cin; co = (r > 255); end
                3:  begin r = a - b - cin; ov = (a < b + cin); end
                4:  begin r = (a + 1) % 256; ov = (a == 255); end
                5:  begin r = (a + 255) % 256; ov = (a == 0); end
                6:  begin r = (b + 1) % 256; ov = (b == 255); end
                7:  begin r = (b + 255) % 256; ov = (b == 0); end
                8:  begin g = (a > b); e = (a == b); l = (a < b); end
                9:  r = (a + 1) * (b + 1);
                10: r = ((a * 2) % 256) * b;
                default: er = 1;
            endcase
        end else begin
            case (c)
                0:  r = a & b;
                1:  r = 255 - (a & b);
                2:  r = a | b;
                3:  r = 255 - (a | b);
                4:  r = a ^ b;
                5:  r = 255 - (a ^ b);
                6:  r = 255 - a;
                7:  r = 255 - b;
                8:  r = a / 2;
                9:  r = (a * 2) % 256;
                10: r = b / 2;
                11: r = (b * 2) % 256;
                12: begin r = ((a << n) | (a >> (8 - n))) % 256; er = (b > 7); end
                13: begin r = ((a >> n) | (a << (8 - n))) % 256; er = (b > 7); end
                default: er = 1;
            endcase
        end
        return {r[15:0], co, ov, g, e, l, er};
    endfunction

    function automatic int exp_lat(input logic m, input logic [3:0] c);
        return (m && (c == 4'd9 || c == 4'd10)) ? 2 : 1;
    endfunction

    function automatic logic [21:0] outs();
        return {bus.RES, bus.COUT, bus.OFLOW, bus.G, bus.E, bus.L, bus.ERR};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic m, input logic [3:0] c, input logic ci,
                         input logic [7:0] a, input logic [7:0] b);
        bus.INP_VALID = v; bus.MODE = m; bus.CMD = c; bus.CIN = ci; bus.OPA = a; bus.OPB = b;
    endtask

    task automatic drive_junk(input logic [1:0] v);
        drive(v, 1'($urandom), 4'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
    endtask

    // Presents one operation (split 0: one beat, 1: A first, 2: B first), then
    // reports the first strobed outputs, edges from capture to strobe, and whether
    // the strobe lasted one cycle with outputs holding afterwards.
    task automatic run_op(input logic m, input logic [3:0] c, input logic ci, input logic [7:0] a,
                          input logic [7:0] b, input int split, input int gap,
                          output logic [21:0] obs, output int lat, output logic held);
        case (split)
            0: begin drive(2'b11, m, c, ci, a, b); step(); end
            1: begin
                drive(2'b01, m, c, ci, a, 8'($urandom)); step();
                for (int i = 0; i < gap; i++) begin drive_junk(2'b00); step(); end
                drive(2'b10, 1'($urandom), 4'($urandom), 1'($urandom), 8'($urandom), b); step();
            end
            default: begin
                drive(2'b10, m, c, ci, 8'($urandom), b); step();
                for (int i = 0; i < gap; i++) begin drive_junk(2'b00); step(); end
                drive(2'b01, 1'($urandom), 4'($urandom), 1'($urandom), a, 8'($urandom)); step();
            end
        endcase
        drive_junk(2'b00);
        lat = -1;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (bus.RES_VALID === 1'b1) begin lat = i; break; end
        end
        obs = outs();
        step();
        held = (bus.RES_VALID === 1'b0) && (outs() === obs);
    endtask

    task automatic test_reset();
        drive(2'b00, 1'b0, 4'd0, 1'b0, 8'd0, 8'd0);
        ce = 1'b1;
        #12;
        checks++;
        if ({bus.BUSY, bus.RES_VALID, outs()} !== 24'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 000000", {bus.BUSY, bus.RES_VALID, outs()});
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add_one_beat();
        logic [21:0] obs; int lat; logic held;
        run_op(1'b1, 4'd0, 1'b0, 8'hFF, 8'h01, 0, 0, obs, lat, held);
        checks++;
        if (obs !== {16'h0100, 1'b1, 5'b0}) begin errors++; $display("FAIL t1_result got %h want %h", obs, {16'h0100, 1'b1, 5'b0}); end
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL t1_latency got %0d want 1", lat); end
        checks++;
        if (held !== 1'b1) begin errors++; $display("FAIL t1_strobe_width got %b want 1", held); end
    endtask

    task automatic test_split();
        logic [21:0] obs, exp; int lat; logic held;
        run_op(1'b1, 4'd1, 1'b0, 8'd5, 8'd7, 1, 3, obs, lat, held);
        checks++;
        if (obs !== {16'hFFFE, 1'b0, 1'b1, 4'b0}) begin errors++; $display("FAIL t2_result got %h want %h", obs, {16'hFFFE, 1'b0, 1'b1, 4'b0}); end
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL t2_latency got %0d want 1", lat); end
        exp = model(1'b1, 4'd3, 1'b1, 8'h80, 8'h80);
        run_op(1'b1, 4'd3, 1'b1, 8'h80, 8'h80, 2, 5, obs, lat, held);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL split_b_first got %h want %h", obs, exp); end
    endtask

    task automatic test_timeout();
        logic [21:0] obs, exp; int lat; logic held; logic bad;
        drive(2'b10, 1'b1, 4'd0, 1'b0, 8'h00, 8'h33); step();
        bad = 1'b0;
        for (int i = 1; i < TIMEOUT; i++) begin
            drive_junk(2'b00); step();
            if (bus.RES_VALID !== 1'b0 || bus.BUSY !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL timeout_early got strobe_or_idle want wait"); end
        step();
        checks++;
        if ({bus.RES_VALID, bus.BUSY, outs()} !== {2'b10, 16'h0000, 5'b0, 1'b1}) begin
            errors++;
            $display("FAIL timeout_error got %h want %h", {bus.RES_VALID, bus.BUSY, outs()}, {2'b10, 16'h0000, 5'b0, 1'b1});
        end
        exp = model(1'b1, 4'd0, 1'b0, 8'h21, 8'h34);
        run_op(1'b1, 4'd0, 1'b0, 8'h21, 8'h34, 2, TIMEOUT - 1, obs, lat, held);
        checks++;
        if (obs !== exp || lat !== 1) begin errors++; $display("FAIL timeout_partner_wins_a got %h lat %0d want %h lat 1", obs, lat, exp); end
        exp = model(1'b0, 4'd4, 1'b0, 8'h5A, 8'hFF);
        run_op(1'b0, 4'd4, 1'b0, 8'h5A, 8'hFF, 1, TIMEOUT - 1, obs, lat, held);
        checks++;
        if (obs !== exp || lat !== 1) begin errors++; $display("FAIL timeout_partner_wins_b got %h lat %0d want %h lat 1", obs, lat, exp); end
    endtask

    task automatic test_mul();
        logic [21:0] obs, exp; int lat; logic held;
        run_op(1'b1, 4'd9, 1'b0, 8'hFF, 8'hFF, 0, 0, obs, lat, held);
        checks++;
        if (obs !== 22'd0 || lat !== 2) begin errors++; $display("FAIL muli_wrap got %h lat %0d want 000000 lat 2", obs, lat); end
        run_op(1'b1, 4'd9, 1'b0, 8'd3, 8'd4, 0, 0, obs, lat, held);
        checks++;
        if (obs !== {16'd20, 6'b0} || lat !== 2) begin errors++; $display("FAIL muli_small got %h lat %0d want %h lat 2", obs, lat, {16'd20, 6'b0}); end
        exp = model(1'b1, 4'd10, 1'b0, 8'hC3, 8'hE7);
        run_op(1'b1, 4'd10, 1'b0, 8'hC3, 8'hE7, 1, 2, obs, lat, held);
        checks++;
        if (obs !== exp || lat !== 2) begin errors++; $display("FAIL muls got %h lat %0d want %h lat 2", obs, lat, exp); end
    endtask

    task automatic test_rotate();
        logic [21:0] obs; int lat; logic held;
        run_op(1'b0, 4'd12, 1'b0, 8'h81, 8'h11, 0, 0, obs, lat, held);
        checks++;
        if (obs !== {16'h0003, 5'b0, 1'b1}) begin errors++; $display("FAIL rol_err got %h want %h", obs, {16'h0003, 5'b0, 1'b1}); end
        run_op(1'b0, 4'd13, 1'b0, 8'h81, 8'h01, 0, 0, obs, lat, held);
        checks++;
        if (obs !== {16'h00C0, 6'b0}) begin errors++; $display("FAIL ror got %h want %h", obs, {16'h00C0, 6'b0}); end
    endtask

    task automatic test_reset_abort();
        logic [21:0] obs; int lat; logic held; logic seen;
        for (int k = 0; k < 2; k++) begin
            run_op(1'b1, 4'd0, 1'b0, 8'h40, 8'h40, 0, 0, obs, lat, held);
            if (k == 0) begin
                drive(2'b01, 1'b1, 4'd0, 1'b0, 8'h11, 8'h00); step();
                drive_junk(2'b00); step(); step();
            end else begin
                drive(2'b11, 1'b1, 4'd9, 1'b0, 8'h05, 8'h05); step();
                drive_junk(2'b00); step();
            end
            #2 rst_n = 1'b0;
            #1;
            checks++;
            if ({bus.BUSY, bus.RES_VALID, outs()} !== 24'd0) begin
                errors++;
                $display("FAIL reset_abort_%0d got %h want 000000", k, {bus.BUSY, bus.RES_VALID, outs()});
            end
            @(negedge clk);
            rst_n = 1'b1;
            seen = 1'b0;
            for (int i = 0; i < TIMEOUT + 4; i++) begin
                step();
                if (bus.RES_VALID !== 1'b0) seen = 1'b1;
            end
            checks++;
            if (seen) begin errors++; $display("FAIL reset_no_strobe_%0d got strobe want none", k); end
        end
    endtask

    task automatic test_ce();
        logic bad;
        drive(2'b11, 1'b1, 4'd0, 1'b0, 8'h10, 8'h20); step();
        drive_junk(2'b00);
        ce = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.RES_VALID !== 1'b0 || bus.BUSY !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL ce_freeze_exec got strobe_or_idle want frozen"); end
        ce = 1'b1;
        step();
        checks++;
        if ({bus.RES_VALID, outs()} !== {1'b1, 16'h0030, 6'b0}) begin
            errors++; $display("FAIL ce_resume got %h want %h", {bus.RES_VALID, outs()}, {1'b1, 16'h0030, 6'b0});
        end
        ce = 1'b0;
        step();
        checks++;
        if ({bus.RES_VALID, bus.RES} !== {1'b0, 16'h0030}) begin
            errors++; $display("FAIL ce_clears_strobe got %h want %h", {bus.RES_VALID, bus.RES}, {1'b0, 16'h0030});
        end
        ce = 1'b1;
        drive(2'b01, 1'b1, 4'd2, 1'b1, 8'h7F, 8'h00); step();
        drive_junk(2'b00);
        ce = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < TIMEOUT + 4; i++) begin
            step();
            if (bus.RES_VALID !== 1'b0) bad = 1'b1;
        end
        ce = 1'b1;
        drive(2'b10, 1'b0, 4'd15, 1'b0, 8'h00, 8'h01); step();
        drive_junk(2'b00); step();
        checks++;
        if (bad || {bus.RES_VALID, outs()} !== {1'b1, model(1'b1, 4'd2, 1'b1, 8'h7F, 8'h01)}) begin
            errors++;
            $display("FAIL ce_freeze_counter got %h early %b want %h", {bus.RES_VALID, outs()}, bad, {1'b1, model(1'b1, 4'd2, 1'b1, 8'h7F, 8'h01)});
        end
    endtask

    task automatic test_back_to_back();
        logic m; logic [3:0] c; logic ci; logic [7:0] a, b; logic [21:0] exp;
        for (int k = 0; k < 10; k++) begin
            m = 1'($urandom);
            c = m ? 4'($urandom_range(10, 0)) : 4'($urandom_range(13, 0));
            ci = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
            exp = model(m, c, ci, a, b);
            drive(2'b11, m, c, ci, a, b); step();
            for (int i = 0; i < exp_lat(m, c); i++) begin drive_junk(2'b11); step(); end
            checks++;
            if ({bus.RES_VALID, outs()} !== {1'b1, exp}) begin
                errors++;
                $display("FAIL back_to_back_%0d m=%0d cmd=%0d got %h want %h", k, m, c, {bus.RES_VALID, outs()}, {1'b1, exp});
            end
        end
        drive_junk(2'b00); step();
    endtask

    task automatic test_random();
        logic m; logic [3:0] c; logic ci; logic [7:0] a, b; logic [21:0] obs, exp;
        int lat, split, gap; logic held;
        for (int k = 0; k < 150; k++) begin
            m = 1'($urandom); c = 4'($urandom); ci = 1'($urandom);
            a = 8'($urandom); b = 8'($urandom);
            split = $urandom_range(2, 0);
            gap = $urandom_range(TIMEOUT - 1, 0);
            exp = model(m, c, ci, a, b);
            run_op(m, c, ci, a, b, split, gap, obs, lat, held);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL random_%0d m=%0d cmd=%0d cin=%0d a=%h b=%h got %h want %h", k, m, c, ci, a, b, obs, exp);
            end
            checks++;
            if (lat !== exp_lat(m, c)) begin errors++; $display("FAIL random_lat_%0d got %0d want %0d", k, lat, exp_lat(m, c)); end
            checks++;
            if (held !== 1'b1) begin errors++; $display("FAIL random_hold_%0d got %b want 1", k, held); end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_one_beat();
        test_split();
        test_timeout();
        test_mul();
        test_rotate();
        test_ce();
        test_back_to_back();
        test_random();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
